serial_shift_reg: RTL and testbench
===================================

SERIAL_SHIFT_REG -- requirements
Module: serial_shift_reg

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request strobe, sampled only in IDLE.
REQ-005 op  input  3  000 NOP, 001 LOAD, 010 SLL, 011 SRL, 100 SRA, 101 ROR, 110 ROL, 111 reserved.
REQ-006 shamt  input  5  shift amount 0..31, captured on accept.
REQ-007 data_in  input  32  load operand from the register-entry select mux.
REQ-008 data_out  output  32  shift register contents, registered.
REQ-009 busy  output  1  high while in state SHIFT.
REQ-010 done  output  1  one-cycle pulse when the result is valid.

Function
REQ-011 States SHALL be IDLE, SHIFT and DONE, held in a registered state variable.
REQ-012 In IDLE, start=1 with a shift or rotate op SHALL capture op and load cnt<=shamt; next state SHIFT if shamt!=0, else DONE.
REQ-013 In IDLE, start=1 with LOAD SHALL write data_reg<=data_in; next state DONE.
REQ-014 In IDLE, start=1 with NOP or 111 SHALL leave data_reg unchanged; next state DONE.
REQ-015 In IDLE, start=0 SHALL hold state and data_reg.
REQ-016 Each SHIFT cycle SHALL perform exactly one 1-bit operation on data_reg:
- SLL: zero fill into bit 0.
- SRL: zero fill into bit 31.
- SRA: bit 31 replicated.
- ROR: bit 0 moves to bit 31.
- ROL: bit 31 moves to bit 0.
REQ-017 Each SHIFT cycle SHALL decrement cnt; when cnt==1 the next state SHALL be DONE.
REQ-018 Latency from the accept edge to done SHALL be shamt+1 cycles: a shift or rotate with shamt=N asserts done in cycle N+1; LOAD, NOP and shamt=0 assert done in cycle 1.
REQ-019 DONE SHALL last exactly one cycle with done=1, busy=0, then return to IDLE unconditionally.
REQ-020 start SHALL be ignored in SHIFT and DONE; no queuing; data_in is not sampled outside an accepted LOAD.
REQ-021 op, shamt and data_in changes after accept SHALL NOT affect an operation in progress.
REQ-022 data_out SHALL equal data_reg at all times, with no combinational path from inputs.
REQ-023 Shift amounts SHALL be unsigned 5-bit; no shift of 32 or more is possible.

Reset
REQ-024 reset_n=0 SHALL immediately force state=IDLE, data_reg=0, cnt=0, busy=0, done=0, independent of clk.
REQ-025 Reset asserted mid-SHIFT or in DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-026 After deassertion, the first accepted start SHALL be on the first rising clk edge with reset_n=1.

Configuration
REQ-027 Macro SERIAL_SHIFT_ROTATE_EN SHALL control rotate support.
REQ-028 With SERIAL_SHIFT_ROTATE_EN defined, ops 101 (ROR) and 110 (ROL) SHALL behave per REQ-016.
REQ-029 Without SERIAL_SHIFT_ROTATE_EN, ops 101 and 110 SHALL behave as NOP per REQ-014: done in cycle 1, data_reg unchanged, no rotate logic synthesized.

Verification
REQ-030 LOAD of 0x8000_0001, then SRA with shamt=4 -> busy high for cycles 1-4, done in cycle 5, data_out=0xF800_0000.
REQ-031 data_reg=0x1234_5678, SLL with shamt=0 -> done in cycle 1, busy never high, data_out=0x1234_5678.
REQ-032 data_reg=0x0000_0001, ROR with shamt=1 -> data_out=0x8000_0000 with done in cycle 2 when the macro is defined; data_out=0x0000_0001 with done in cycle 1 when it is not.
REQ-033 data_reg=0xFFFF_FFFF, SRL with shamt=31; start pulsed with LOAD 0xAAAA_AAAA during cycle 10 -> pulse ignored, done in cycle 32, data_out=0x0000_0001.
REQ-034 SLL with shamt=20 on 0x0000_0001; reset_n pulsed low in cycle 7 -> data_out=0 and busy=0 immediately, no done pulse, next LOAD accepted normally.

Source files
------------

// File: rtl/serial_shift_reg_if.sv
// Handshake/bus bundle for serial_shift_reg.
// master: the requester driving start/op/shamt/data_in.
// slave:  the shift register itself.
interface serial_shift_reg_if;
    logic        start;
    logic [2:0]  op;
    logic [4:0]  shamt;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        busy;
    logic        done;

    modport master (
        output start, op, shamt, data_in,
        input  data_out, busy, done
    );

    modport slave (
        input  start, op, shamt, data_in,
        output data_out, busy, done
    );
endinterface

// File: rtl/serial_shift_reg.sv
// serial_shift_reg: 32-bit multi-cycle shift unit, one bit position per cycle.
// Ops: 000 NOP, 001 LOAD, 010 SLL, 011 SRL, 100 SRA, 101 ROR, 110 ROL, 111 reserved.
// Configuration macro: SERIAL_SHIFT_ROTATE_EN enables ROR/ROL; when it is
// undefined, 101/110 complete as NOP and no rotate datapath exists.
module serial_shift_reg (
    input  logic               clk,
    input  logic               reset_n,
    serial_shift_reg_if.slave  bus
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_SRL  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ROL  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] data_q,  data_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic [2:0]  op_q,    op_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        op_d    = op_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_LOAD: begin
                            data_d  = bus.data_in;
                            state_d = ST_DONE;
                        end
                        OP_SLL, OP_SRL, OP_SRA
`ifdef SERIAL_SHIFT_ROTATE_EN
                        , OP_ROR, OP_ROL
`endif
                        : begin
                            op_d  = bus.op;
                            cnt_d = bus.shamt;
                            if (bus.shamt != 5'd0) begin
                                state_d = ST_SHIFT;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                        default: begin
                            // NOP, reserved, and rotates when compiled out.
                            state_d = ST_DONE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                case (op_q)
                    OP_SLL:  data_d = {data_q[30:0], 1'b0};
                    OP_SRL:  data_d = {1'b0, data_q[31:1]};
                    OP_SRA:  data_d = {data_q[31], data_q[31:1]};
`ifdef SERIAL_SHIFT_ROTATE_EN
                    OP_ROR:  data_d = {data_q[0], data_q[31:1]};
                    OP_ROL:  data_d = {data_q[30:0], data_q[31]};
`endif
                    default: data_d = data_q;
                endcase
                cnt_d = cnt_q - 5'd1;
                // cnt of 0 cannot occur here; treat it as last step defensively.
                if (cnt_q <= 5'd1) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State, data and flag registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            data_q  <= 32'd0;
            cnt_q   <= 5'd0;
            op_q    <= OP_NOP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.data_out = data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_serial_shift_reg.sv
// Scoreboard bench for serial_shift_reg. Expected result and latency are
// pushed when an op is driven and popped when done is observed.
module tb_serial_shift_reg;

    logic clk;
    logic reset_n;
    serial_shift_reg_if bus ();

    serial_shift_reg dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SERIAL_SHIFT_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_reg;
    int          n_checks;
    int          n_pass;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: result of op applied shamt times.
    function automatic exp_t model_op(input logic [2:0] o, input logic [4:0] sh,
                                      input logic [31:0] d, input logic [31:0] cur);
        exp_t        e;
        logic [31:0] r;
        int          n;
        n     = int'(sh);
        r     = cur;
        e.lat = 1;
        case (o)
            3'b001: r = d;
            3'b010: begin r = cur << n; e.lat = n + 1; end
            3'b011: begin r = cur >> n; e.lat = n + 1; end
            3'b100: begin r = $unsigned($signed(cur) >>> n); e.lat = n + 1; end
            3'b101: if (ROT_EN) begin
                        r = (n == 0) ? cur : ((cur >> n) | (cur << (32 - n)));
                        e.lat = n + 1;
                    end
            3'b110: if (ROT_EN) begin
                        r = (n == 0) ? cur : ((cur << n) | (cur >> (32 - n)));
                        e.lat = n + 1;
                    end
            default: r = cur;
        endcase
        e.data = r;
        return e;
    endfunction

    // Must be called at a negedge with the DUT idle. inj: cycle for a stray LOAD start.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [4:0] sh,
                         input logic [31:0] d, input int inj);
        exp_t e;
        exp_t got_e;
        bit   got;
        e = model_op(o, sh, d, model_reg);
        model_reg = e.data;
        exp_q.push_back(e);
        bus.start   = 1'b1;
        bus.op      = o;
        bus.shamt   = sh;
        bus.data_in = d;
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start   = 1'b0;
                bus.op      = 3'($urandom);
                bus.shamt   = 5'($urandom);
                bus.data_in = $urandom;
            end
            if (inj != 0 && k == inj) begin
                bus.start   = 1'b1;
                bus.op      = 3'b001;
                bus.data_in = 32'hAAAA_AAAA;
            end else if (inj != 0 && k == inj + 1) begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                got   = 1'b1;
                got_e = exp_q.pop_front();
                check_val({tag, "_data"}, bus.data_out, got_e.data);
                check_val({tag, "_lat"}, 32'(k), 32'(got_e.lat));
                check_val({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
            end else begin
                check_val({tag, "_busy"}, {31'd0, bus.busy}, {31'd0, (k < e.lat)});
            end
        end
        if (!got) begin
            check_val({tag, "_timeout_done"}, {31'd0, bus.done}, 32'd1);
            void'(exp_q.pop_front());
        end
        bus.start = 1'b0;
        @(negedge clk);
        check_val({tag, "_done_one_cycle"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        model_reg   = 32'd0;
        bus.start   = 1'b0;
        bus.op      = 3'b000;
        bus.shamt   = 5'd0;
        bus.data_in = 32'd0;
        reset_n     = 1'b1;
        #1 reset_n  = 1'b0;
        #2;
        check_val("rst_data", bus.data_out, 32'd0);
        check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_val("rst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        // First edge after release accepts the LOAD.
        reset_n = 1'b1;
        do_op("load_8001", 3'b001, 5'd0, 32'h8000_0001, 0);
        do_op("sra4", 3'b100, 5'd4, 32'h0, 0);
        check_val("sra4_value", bus.data_out, 32'hF800_0000);

        do_op("load_1234", 3'b001, 5'd0, 32'h1234_5678, 0);
        do_op("sll0", 3'b010, 5'd0, 32'hDEAD_BEEF, 0);
        check_val("sll0_value", bus.data_out, 32'h1234_5678);

        do_op("load_1", 3'b001, 5'd0, 32'h0000_0001, 0);
        do_op("ror1", 3'b101, 5'd1, 32'h0, 0);
        check_val("ror1_value", bus.data_out, ROT_EN ? 32'h8000_0000 : 32'h0000_0001);

        do_op("load_ff", 3'b001, 5'd0, 32'hFFFF_FFFF, 0);
        do_op("srl31", 3'b011, 5'd31, 32'h0, 10);
        check_val("srl31_value", bus.data_out, 32'h0000_0001);

        do_op("load_c3", 3'b001, 5'd0, 32'hC35A_0F81, 0);
        do_op("nop", 3'b000, 5'd9, 32'h1111_1111, 0);
        do_op("rsvd", 3'b111, 5'd3, 32'h2222_2222, 0);
        do_op("rol5", 3'b110, 5'd5, 32'h0, 0);
        do_op("ror31", 3'b101, 5'd31, 32'h0, 0);
        do_op("sra7", 3'b100, 5'd7, 32'h0, 0);
        for (int i = 0; i < 6; i++) begin
            do_op("rnd_load", 3'b001, 5'd0, $urandom, 0);
            do_op("rnd_op", 3'(3'd2 + 3'($urandom_range(4))), 5'($urandom_range(12)), 32'h0, 0);
        end

        // Abort an SLL by 20 with reset in cycle 7.
        do_op("load_one", 3'b001, 5'd0, 32'h0000_0001, 0);
        bus.start = 1'b1;
        bus.op    = 3'b010;
        bus.shamt = 5'd20;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check_val("abort_busy_before", {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_val("abort_data", bus.data_out, 32'd0);
        check_val("abort_busy", {31'd0, bus.busy}, 32'd0);
        check_val("abort_done", {31'd0, bus.done}, 32'd0);
        model_reg = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) begin
                check_val("abort_no_done", {30'd0, bus.busy, bus.done}, 32'd0);
            end
        end
        check_val("abort_still_zero", bus.data_out, 32'd0);
        do_op("post_load", 3'b001, 5'd0, 32'h5A5A_A5A5, 0);
        do_op("post_srl3", 3'b011, 5'd3, 32'h0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
